// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control FSM: opcode values, FSM state encoding,
// write-back and PC source encodings, the decoded instruction class and the
// bundle of registered control outputs.
package cpu_pkg;

   // Opcode values (low 5 bits of the instruction word)
   localparam logic [4:0] OpMv    = 5'b00000;
   localparam logic [4:0] OpAdd   = 5'b00001;
   localparam logic [4:0] OpSub   = 5'b00010;
   localparam logic [4:0] OpCmp   = 5'b00011;
   localparam logic [4:0] OpLd    = 5'b00100;
   localparam logic [4:0] OpSt    = 5'b00101;
   localparam logic [4:0] OpMvi   = 5'b10000;
   localparam logic [4:0] OpAddi  = 5'b10001;
   localparam logic [4:0] OpSubi  = 5'b10010;
   localparam logic [4:0] OpCmpi  = 5'b10011;
   localparam logic [4:0] OpMvhi  = 5'b10110;
   localparam logic [4:0] OpJr    = 5'b01000;
   localparam logic [4:0] OpJzr   = 5'b01001;
   localparam logic [4:0] OpJnr   = 5'b01010;
   localparam logic [4:0] OpCallr = 5'b01100;
   localparam logic [4:0] OpJ     = 5'b11000;
   localparam logic [4:0] OpJz    = 5'b11001;
   localparam logic [4:0] OpJn    = 5'b11010;
   localparam logic [4:0] OpCall  = 5'b11100;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      WbMem  = 3'b000,
      WbAlu  = 3'b001,
      WbPc2  = 3'b010,
      WbRy   = 3'b011,
      WbImm8 = 3'b100
   } wb_src_e;

   typedef enum logic [1:0] {
      PcBranch = 2'b00,
      PcReg    = 2'b01,
      PcNext   = 2'b10
   } pc_src_e;

   typedef enum logic [1:0] {
      JmpNone   = 2'd0,
      JmpAlways = 2'd1,
      JmpIfZ    = 2'd2,
      JmpIfN    = 2'd3
   } jump_e;

   typedef struct packed {
      logic    legal;
      logic    alu_sub;     // ALU subtracts
      logic    use_imm;     // ALU B operand is the extended immediate
      logic    ext_imm11;   // immediate is the 11-bit jump field
      logic    sets_flags;  // NZ flags load at the end of EXEC
      logic    has_wb;      // instruction retires in WB
      logic    is_mem;
      logic    is_store;
      jump_e   jump;
      logic    jump_reg;    // target comes from a register
      logic    link;        // writes pc+2 into R7
      wb_src_e wb_src;
   } instr_class_t;

   typedef struct packed {
      logic    mem_req;
      logic    mem_we;
      logic    mem_sel;
      logic    ir_load;
      logic    pc_write;
      pc_src_e pc_src;
      logic    reg_write;
      logic    reg_dst;
      wb_src_e wb_src;
      logic    alu_op;
      logic    alu_src;
      logic    ext_sel;
      logic    trap;
   } ctrl_t;

   localparam ctrl_t CtrlIdle = '{
      mem_req:   1'b0,
      mem_we:    1'b0,
      mem_sel:   1'b0,
      ir_load:   1'b0,
      pc_write:  1'b0,
      pc_src:    PcNext,
      reg_write: 1'b0,
      reg_dst:   1'b0,
      wb_src:    WbMem,
      alu_op:    1'b0,
      alu_src:   1'b0,
      ext_sel:   1'b0,
      trap:      1'b0
   };

   // PC source for a retiring instruction given the current NZ flags.
   function automatic pc_src_e pc_src_sel(instr_class_t cls, logic n, logic z);
      logic    taken;
      pc_src_e sel;
      case (cls.jump)
         JmpAlways: taken = 1'b1;
         JmpIfZ:    taken = z;
         JmpIfN:    taken = n;
         default:   taken = 1'b0;
      endcase
      if (!taken) begin
         sel = PcNext;
      end else if (cls.jump_reg) begin
         sel = PcReg;
      end else begin
         sel = PcBranch;
      end
      return sel;
   endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier.
// Ports:
//   opcode  in   OPC_W  opcode field of the instruction register
//   cls     out  struct decoded instruction class (legal flag, ALU, memory,
//                       jump and write-back attributes)
module instr_class_decode
   import cpu_pkg::*;
#(
   parameter int unsigned OPC_W = 5
) (
   input  logic [OPC_W-1:0] opcode,
   output instr_class_t     cls
);

   always_comb begin
      cls        = '0;
      cls.legal  = 1'b1;
      cls.jump   = JmpNone;
      cls.wb_src = WbMem;
      case (opcode)
         OPC_W'(OpMv): begin
            cls.has_wb = 1'b1;
            cls.wb_src = WbRy;
         end
         OPC_W'(OpAdd): begin
            cls.has_wb     = 1'b1;
            cls.sets_flags = 1'b1;
            cls.wb_src     = WbAlu;
         end
         OPC_W'(OpSub): begin
            cls.has_wb     = 1'b1;
            cls.sets_flags = 1'b1;
            cls.alu_sub    = 1'b1;
            cls.wb_src     = WbAlu;
         end
         OPC_W'(OpCmp): begin
            cls.sets_flags = 1'b1;
            cls.alu_sub    = 1'b1;
         end
         OPC_W'(OpLd): begin
            cls.is_mem = 1'b1;
            cls.has_wb = 1'b1;
            cls.wb_src = WbMem;
         end
         OPC_W'(OpSt): begin
            cls.is_mem   = 1'b1;
            cls.is_store = 1'b1;
         end
         OPC_W'(OpMvi), OPC_W'(OpMvhi): begin
            cls.has_wb = 1'b1;
            cls.wb_src = WbImm8;
         end
         OPC_W'(OpAddi): begin
            cls.has_wb     = 1'b1;
            cls.sets_flags = 1'b1;
            cls.use_imm    = 1'b1;
            cls.wb_src     = WbAlu;
         end
         OPC_W'(OpSubi): begin
            cls.has_wb     = 1'b1;
            cls.sets_flags = 1'b1;
            cls.use_imm    = 1'b1;
            cls.alu_sub    = 1'b1;
            cls.wb_src     = WbAlu;
         end
         OPC_W'(OpCmpi): begin
            cls.sets_flags = 1'b1;
            cls.use_imm    = 1'b1;
            cls.alu_sub    = 1'b1;
         end
         OPC_W'(OpJr): begin
            cls.jump     = JmpAlways;
            cls.jump_reg = 1'b1;
         end
         OPC_W'(OpJzr): begin
            cls.jump     = JmpIfZ;
            cls.jump_reg = 1'b1;
         end
         OPC_W'(OpJnr): begin
            cls.jump     = JmpIfN;
            cls.jump_reg = 1'b1;
         end
         OPC_W'(OpCallr): begin
            cls.jump     = JmpAlways;
            cls.jump_reg = 1'b1;
            cls.link     = 1'b1;
            cls.has_wb   = 1'b1;
            cls.wb_src   = WbPc2;
         end
         OPC_W'(OpJ): begin
            cls.jump      = JmpAlways;
            cls.ext_imm11 = 1'b1;
         end
         OPC_W'(OpJz): begin
            cls.jump      = JmpIfZ;
            cls.ext_imm11 = 1'b1;
         end
         OPC_W'(OpJn): begin
            cls.jump      = JmpIfN;
            cls.ext_imm11 = 1'b1;
         end
         OPC_W'(OpCall): begin
            cls.jump      = JmpAlways;
            cls.ext_imm11 = 1'b1;
            cls.link      = 1'b1;
            cls.has_wb    = 1'b1;
            cls.wb_src    = WbPc2;
         end
         default: cls.legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB), with a
// memory wait timeout and a sticky TRAP state. All outputs are registered; the
// next-cycle output word is decoded from the next state, the IR class and the
// next flag values, so outputs always line up with state_o.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   instr                 memory read data, captured into the internal IR
//   mem_ready             memory completes the current request
//   alu_n, alu_z          ALU result flags for the current operation
//   mem_req/we/sel        memory request, write enable, 0=fetch 1=data
//   ir_load               IR capture pulse (high during DECODE)
//   pc_write, pc_src      PC update and source select
//   reg_write, reg_dst    register write enable, 0=Rx 1=R7
//   wb_src                write-back source select
//   alu_op/alu_src/ext_sel ALU and immediate controls
//   flag_n, flag_z        registered NZ flags
//   trap                  sticky fault indication
//   state_o               current state for debug
module cpu_control_fsm
   import cpu_pkg::*;
#(
   parameter int unsigned OPC_W       = 5,
   parameter int unsigned INSTR_W     = 16,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [INSTR_W-1:0] instr,
   input  logic               mem_ready,
   input  logic               alu_n,
   input  logic               alu_z,
   output logic               mem_req,
   output logic               mem_we,
   output logic               mem_sel,
   output logic               ir_load,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               reg_write,
   output logic               reg_dst,
   output logic [2:0]         wb_src,
   output logic               alu_op,
   output logic               alu_src,
   output logic               ext_sel,
   output logic               flag_n,
   output logic               flag_z,
   output logic               trap,
   output logic [2:0]         state_o
);

   localparam int unsigned CntW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               flag_n_q, flag_n_d;
   logic               flag_z_q, flag_z_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [CntW-1:0]    cnt_inc;
   logic               timeout;
   ctrl_t              ctrl_q, ctrl_d;
   instr_class_t       cls;

   instr_class_decode #(
      .OPC_W(OPC_W)
   ) u_decode (
      .opcode(ir_q[OPC_W-1:0]),
      .cls   (cls)
   );

   // Immediate/register fields are consumed by the datapath, not here.
   logic unused_ir;
   assign unused_ir = ^ir_q[INSTR_W-1:OPC_W];

   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
   assign timeout = (32'(cnt_inc) >= MEM_TIMEOUT);

   // Next state, IR, flags and wait counter
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      flag_n_d = flag_n_q;
      flag_z_d = flag_z_q;
      cnt_d    = cnt_q;
      case (state_q)
         StFetch: begin
            // The first cycle after reset has no request on the bus yet, so
            // mem_ready is ignored until mem_req is actually driven.
            if (ctrl_q.mem_req) begin
               if (mem_ready) begin
                  ir_d    = instr;
                  state_d = StDecode;
               end else begin
                  cnt_d = cnt_inc;
                  if (timeout) state_d = StTrap;
               end
            end
         end
         StDecode: state_d = cls.legal ? StExec : StTrap;
         StExec: begin
            if (cls.sets_flags) begin
               flag_n_d = alu_n;
               flag_z_d = alu_z;
            end
            if (cls.is_mem) begin
               state_d = StMem;
               cnt_d   = '0;
            end else if (cls.has_wb) begin
               state_d = StWb;
            end else begin
               state_d = StFetch;
               cnt_d   = '0;
            end
         end
         StMem: begin
            if (mem_ready) begin
               state_d = cls.is_store ? StFetch : StWb;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
               if (timeout) state_d = StTrap;
            end
         end
         StWb: begin
            state_d = StFetch;
            cnt_d   = '0;
         end
         StTrap:  state_d = StTrap;
         default: state_d = StTrap;
      endcase
   end

   // Output word for the cycle spent in state_d
   always_comb begin
      ctrl_d = CtrlIdle;
      case (state_d)
         StFetch: ctrl_d.mem_req = 1'b1;
         StDecode: ctrl_d.ir_load = 1'b1;
         StExec: begin
            ctrl_d.alu_op  = cls.alu_sub;
            ctrl_d.alu_src = cls.use_imm;
            ctrl_d.ext_sel = cls.ext_imm11;
            // Instructions without write-back retire here, stores included.
            if (!cls.has_wb) begin
               ctrl_d.pc_write = 1'b1;
               ctrl_d.pc_src   = pc_src_sel(cls, flag_n_d, flag_z_d);
            end
         end
         StMem: begin
            ctrl_d.mem_req = 1'b1;
            ctrl_d.mem_sel = 1'b1;
            ctrl_d.mem_we  = cls.is_store;
         end
         StWb: begin
            // ALU controls stay stable so the ALU result is still valid.
            ctrl_d.alu_op    = cls.alu_sub;
            ctrl_d.alu_src   = cls.use_imm;
            ctrl_d.ext_sel   = cls.ext_imm11;
            ctrl_d.reg_write = 1'b1;
            ctrl_d.reg_dst   = cls.link;
            ctrl_d.wb_src    = cls.wb_src;
            ctrl_d.pc_write  = 1'b1;
            ctrl_d.pc_src    = pc_src_sel(cls, flag_n_d, flag_z_d);
         end
         StTrap: ctrl_d.trap = 1'b1;
         default: ctrl_d = CtrlIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= StFetch;
         ir_q     <= '0;
         flag_n_q <= 1'b0;
         flag_z_q <= 1'b0;
         cnt_q    <= '0;
         ctrl_q   <= CtrlIdle;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         flag_n_q <= flag_n_d;
         flag_z_q <= flag_z_d;
         cnt_q    <= cnt_d;
         ctrl_q   <= ctrl_d;
      end
   end

   assign mem_req   = ctrl_q.mem_req;
   assign mem_we    = ctrl_q.mem_we;
   assign mem_sel   = ctrl_q.mem_sel;
   assign ir_load   = ctrl_q.ir_load;
   assign pc_write  = ctrl_q.pc_write;
   assign pc_src    = ctrl_q.pc_src;
   assign reg_write = ctrl_q.reg_write;
   assign reg_dst   = ctrl_q.reg_dst;
   assign wb_src    = ctrl_q.wb_src;
   assign alu_op    = ctrl_q.alu_op;
   assign alu_src   = ctrl_q.alu_src;
   assign ext_sel   = ctrl_q.ext_sel;
   assign trap      = ctrl_q.trap;
   assign flag_n    = flag_n_q;
   assign flag_z    = flag_z_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: hand-computed expectations per cycle.
module tb_cpu_control_fsm;

   localparam int unsigned SFetch  = 0;
   localparam int unsigned SDecode = 1;
   localparam int unsigned SExec   = 2;
   localparam int unsigned SMem    = 3;
   localparam int unsigned SWb     = 4;
   localparam int unsigned STrap   = 5;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] instr;
   logic        mem_ready, alu_n, alu_z;
   logic        mem_req, mem_we, mem_sel, ir_load, pc_write;
   logic [1:0]  pc_src;
   logic        reg_write, reg_dst;
   logic [2:0]  wb_src;
   logic        alu_op, alu_src, ext_sel, flag_n, flag_z, trap;
   logic [2:0]  state_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   cpu_control_fsm #(
      .OPC_W      (5),
      .INSTR_W    (16),
      .MEM_TIMEOUT(15)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .instr    (instr),
      .mem_ready(mem_ready),
      .alu_n    (alu_n),
      .alu_z    (alu_z),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_sel  (mem_sel),
      .ir_load  (ir_load),
      .pc_write (pc_write),
      .pc_src   (pc_src),
      .reg_write(reg_write),
      .reg_dst  (reg_dst),
      .wb_src   (wb_src),
      .alu_op   (alu_op),
      .alu_src  (alu_src),
      .ext_sel  (ext_sel),
      .flag_n   (flag_n),
      .flag_z   (flag_z),
      .trap     (trap),
      .state_o  (state_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Must be called while in FETCH with mem_req high; leaves the FSM in DECODE.
   task automatic fetch(input logic [15:0] word, input string tag);
      instr     = word;
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check_eq({tag, " decode"}, state_o, SDecode);
      check_eq({tag, " ir_load"}, ir_load, 1);
   endtask

   task automatic check_enables_off(input string tag);
      check_eq({tag, " mem_req"}, mem_req, 0);
      check_eq({tag, " mem_we"}, mem_we, 0);
      check_eq({tag, " reg_write"}, reg_write, 0);
      check_eq({tag, " pc_write"}, pc_write, 0);
      check_eq({tag, " ir_load"}, ir_load, 0);
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      step();
      check_eq("rst state", state_o, SFetch);
      check_eq("rst trap", trap, 0);
      check_eq("rst flag_n", flag_n, 0);
      check_eq("rst flag_z", flag_z, 0);
      check_enables_off("rst");
      reset_n = 1'b1;
      step();
      check_eq("post-rst mem_req", mem_req, 1);
      check_eq("post-rst mem_sel", mem_sel, 0);
   endtask

   initial begin
      reset_n   = 1'b0;
      instr     = '0;
      mem_ready = 1'b0;
      alu_n     = 1'b0;
      alu_z     = 1'b0;
      step();
      do_reset();

      // add with mem_ready held high: FETCH, DECODE, EXEC, WB
      fetch(16'h0001, "add");
      step();
      check_eq("add exec state", state_o, SExec);
      check_eq("add exec alu_op", alu_op, 0);
      check_eq("add exec pc_write", pc_write, 0);
      step();
      check_eq("add wb state", state_o, SWb);
      check_eq("add wb reg_write", reg_write, 1);
      check_eq("add wb wb_src", wb_src, 3'b001);
      check_eq("add wb pc_write", pc_write, 1);
      check_eq("add wb pc_src", pc_src, 2'b10);
      step();
      check_eq("add next fetch", state_o, SFetch);
      check_eq("add pc_write once", pc_write, 0);

      // cmp with alu_z=1, then jz taken
      fetch(16'h0003, "cmp");
      alu_z = 1'b1;
      alu_n = 1'b0;
      step();
      check_eq("cmp alu_op", alu_op, 1);
      check_eq("cmp alu_src", alu_src, 0);
      check_eq("cmp pc_write", pc_write, 1);
      check_eq("cmp reg_write", reg_write, 0);
      step();
      alu_z = 1'b0;
      check_eq("cmp back to fetch", state_o, SFetch);
      check_eq("cmp flag_z", flag_z, 1);
      check_eq("cmp no reg_write", reg_write, 0);
      fetch(16'h0019, "jz1");
      step();
      check_eq("jz taken pc_src", pc_src, 2'b00);
      check_eq("jz taken pc_write", pc_write, 1);
      check_eq("jz ext_sel", ext_sel, 1);
      step();

      // cmpi with alu_z=0, alu_n=1, then jz not taken, jn and jnr taken
      fetch(16'h0013, "cmpi");
      alu_n = 1'b1;
      step();
      check_eq("cmpi alu_src", alu_src, 1);
      check_eq("cmpi ext_sel", ext_sel, 0);
      check_eq("cmpi alu_op", alu_op, 1);
      step();
      alu_n = 1'b0;
      check_eq("cmpi flag_z", flag_z, 0);
      check_eq("cmpi flag_n", flag_n, 1);
      fetch(16'h0019, "jz2");
      step();
      check_eq("jz not taken pc_src", pc_src, 2'b10);
      check_eq("jz not taken pc_write", pc_write, 1);
      step();
      fetch(16'h001A, "jn");
      step();
      check_eq("jn taken pc_src", pc_src, 2'b00);
      step();
      fetch(16'h000A, "jnr");
      step();
      check_eq("jnr taken pc_src", pc_src, 2'b01);
      step();
      check_eq("flag_n held by jumps", flag_n, 1);

      // call: link write to R7 with pc+2, PC to branch target in WB
      fetch(16'h001C, "call");
      step();
      check_eq("call exec pc_write", pc_write, 0);
      step();
      check_eq("call wb state", state_o, SWb);
      check_eq("call wb reg_dst", reg_dst, 1);
      check_eq("call wb wb_src", wb_src, 3'b010);
      check_eq("call wb pc_src", pc_src, 2'b00);
      check_eq("call wb pc_write", pc_write, 1);
      step();

      // mvi and mv write-back sources
      fetch(16'h0010, "mvi");
      step();
      step();
      check_eq("mvi wb_src", wb_src, 3'b100);
      check_eq("mvi reg_dst", reg_dst, 0);
      step();
      fetch(16'h0000, "mv");
      step();
      step();
      check_eq("mv wb_src", wb_src, 3'b011);
      step();

      // ld with mem_ready withheld for 3 MEM cycles
      fetch(16'h0004, "ld");
      step();
      check_eq("ld exec pc_write", pc_write, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("ld mem%0d state", i), state_o, SMem);
         check_eq($sformatf("ld mem%0d req", i), mem_req, 1);
         check_eq($sformatf("ld mem%0d sel", i), mem_sel, 1);
         check_eq($sformatf("ld mem%0d we", i), mem_we, 0);
         if (i == 3) mem_ready = 1'b1;
         step();
      end
      mem_ready = 1'b0;
      check_eq("ld wb state", state_o, SWb);
      check_eq("ld wb wb_src", wb_src, 3'b000);
      check_eq("ld wb reg_write", reg_write, 1);
      step();

      // st: retires in EXEC, MEM writes, returns to FETCH
      fetch(16'h0005, "st");
      step();
      check_eq("st exec pc_write", pc_write, 1);
      step();
      check_eq("st mem we", mem_we, 1);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check_eq("st back to fetch", state_o, SFetch);
      check_eq("st no reg_write", reg_write, 0);

      // mem_ready at exactly the 15th FETCH wait cycle: completion wins
      for (int c = 1; c < 15; c++) step();
      check_eq("fetch wait 15 state", state_o, SFetch);
      fetch(16'h0001, "late ready");
      check_eq("late ready no trap", trap, 0);
      step();
      step();
      step();

      // 15 FETCH cycles with no mem_ready: trap
      for (int c = 1; c <= 15; c++) begin
         if (c == 15) check_eq("timeout pre trap", trap, 0);
         step();
      end
      check_eq("timeout state", state_o, STrap);
      check_eq("timeout trap", trap, 1);
      check_enables_off("timeout");
      mem_ready = 1'b1;
      step();
      step();
      check_eq("trap sticky", state_o, STrap);
      check_enables_off("trap sticky");
      do_reset();

      // illegal opcode 00110: TRAP after DECODE, held until reset
      fetch(16'h0006, "illegal");
      step();
      check_eq("illegal trap state", state_o, STrap);
      check_eq("illegal trap", trap, 1);
      for (int c = 0; c < 3; c++) step();
      check_eq("illegal held", trap, 1);
      do_reset();

      // reset in MEM of a store aborts it
      fetch(16'h0003, "cmp2");
      alu_z = 1'b1;
      step();
      step();
      alu_z = 1'b0;
      check_eq("cmp2 flag_z", flag_z, 1);
      fetch(16'h0005, "st2");
      step();
      step();
      check_eq("st2 in mem", state_o, SMem);
      check_eq("st2 mem_req", mem_req, 1);
      reset_n = 1'b0;
      step();
      check_eq("st2 rst state", state_o, SFetch);
      check_eq("st2 rst flag_z", flag_z, 0);
      check_enables_off("st2 rst");
      reset_n = 1'b1;
      step();
      check_eq("st2 refetch", mem_req, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_control_fsm.md
CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
Parameters: name, default, meaning.
REQ-001 The block SHALL have parameter OPC_W, default 5, giving the opcode width taken from instr[OPC_W-1:0].
REQ-002 The block SHALL have parameter INSTR_W, default 16, giving the instruction word width.
REQ-003 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of cycles to wait for mem_ready before trapping.

Ports: name, direction, width, meaning.
REQ-004 The ports SHALL be, in order:
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- instr  in  INSTR_W  memory read data; captured into the internal IR.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_n, alu_z  in  1 each  ALU negative and zero results for the current operation.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_sel  out  1  0 = instruction fetch, 1 = data access.
- ir_load  out  1  capture instr into IR.
- pc_write  out  1  update PC.
- pc_src  out  2  00 = branch target, 01 = register-indirect, 10 = pc+2.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0 = Rx, 1 = R7.
- wb_src  out  3  000 = memory, 001 = ALU, 010 = pc+2, 011 = Ry, 100 = imm8.
- alu_op  out  1  0 = add, 1 = sub.
- alu_src  out  1  0 = rd2, 1 = imm_ext.
- ext_sel  out  1  0 = imm8, 1 = imm11.
- flag_n, flag_z  out  1 each  registered NZ flags.
- trap  out  1  sticky fault indication.
- state_o  out  3  current state, for debug.

Function
REQ-010 The block SHALL implement states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-011 In FETCH the block SHALL assert mem_req=1 and mem_sel=0; on mem_ready it SHALL assert ir_load for one cycle and move to DECODE; with no mem_ready it SHALL stay in FETCH.
REQ-012 DECODE SHALL last exactly one cycle and SHALL classify the IR opcode.
REQ-013 Legal opcodes SHALL be mv 00000, add 00001, sub 00010, cmp 00011, ld 00100, st 00101, mvi 10000, addi 10001, subi 10010, cmpi 10011, mvhi 10110, jr 01000, jzr 01001, jnr 01010, callr 01100, j 11000, jz 11001, jn 11010 and call 11100.
REQ-014 Any other opcode SHALL cause a move to TRAP.
REQ-015 EXEC SHALL last one cycle for ALU operations: add/addi SHALL use alu_op=0 and sub/subi/cmp/cmpi SHALL use alu_op=1; the immediate forms SHALL use alu_src=1 and ext_sel=0.
REQ-016 cmp and cmpi SHALL assert no reg_write.
REQ-017 ld and st SHALL go EXEC -> MEM; MEM SHALL hold mem_req=1 and mem_sel=1, with mem_we=1 for st only, until mem_ready.
REQ-018 Loads SHALL continue MEM -> WB with wb_src=000; stores SHALL continue MEM -> FETCH.
REQ-019 WB SHALL assert reg_write for exactly one cycle together with the wb_src of the instruction: mv 011, ALU ops 001, mvi/mvhi 100, call/callr 010 with reg_dst=1.
REQ-020 pc_write SHALL pulse exactly once per retired instruction, on the final cycle (WB, or EXEC/MEM for instructions with no write-back).
REQ-021 pc_src SHALL be 10 by default; 00 for j, and for jz/jn when taken; 01 for jr, and for jzr/jnr when taken.
REQ-022 jz and jzr SHALL be taken when flag_z=1; jn and jnr SHALL be taken when flag_n=1.
REQ-023 flag_n and flag_z SHALL be loaded from alu_n and alu_z at the end of EXEC for add, sub, cmp, addi, subi and cmpi only; all other instructions SHALL hold the flags.
REQ-024 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without mem_ready.
REQ-025 When the wait counter reaches MEM_TIMEOUT, the block SHALL move to TRAP.
REQ-026 The wait counter SHALL saturate and never wrap.
REQ-027 If mem_ready arrives on the same cycle the counter reaches MEM_TIMEOUT, completion SHALL win.
REQ-028 In TRAP the block SHALL assert trap=1 and drive every enable (mem_req, mem_we, reg_write, pc_write, ir_load) to 0, and SHALL stay in TRAP until reset.
REQ-029 All outputs SHALL be registered or decoded from state plus IR only; no output SHALL depend combinationally on instr.

Reset
REQ-030 When reset_n=0 at a clock edge, the state SHALL become FETCH, and IR, the flags, trap and the wait counter SHALL be cleared.
REQ-031 During reset every enable output SHALL be 0, and SHALL stay 0 until the first cycle after reset_n rises.
REQ-032 A reset asserted mid-operation, including during MEM with mem_req high, SHALL abort the operation with no pc_write or reg_write on that edge.

Structure
REQ-040 A shared package cpu_pkg SHALL hold the opcode localparams, the state enum, and the wb_src and pc_src encodings.
REQ-041 The combinational opcode-to-class decode SHALL be one sub-module, instr_class_decode, instantiated once in this block.

Verification
REQ-050 Run add (00001) with mem_ready held at 1: expect FETCH, DECODE, EXEC, WB, i.e. 4 cycles, with reg_write=1 and wb_src=001 in WB and one pc_write pulse.
REQ-051 Run cmp where the ALU returns alu_z=1, then jz: expect flag_z=1 and, for jz, pc_src=00 with pc_write=1; repeat with alu_z=0 and expect pc_src=10.
REQ-052 Run ld with mem_ready withheld for 3 cycles in MEM: expect mem_req=1 and mem_sel=1 held for 4 cycles, then WB with wb_src=000.
REQ-053 Hold FETCH with no mem_ready for 15 cycles: expect trap=1 and all enables 0; assert mem_ready exactly at cycle 15 and expect no trap.
REQ-054 Load opcode 00110: expect TRAP at the cycle after DECODE, held until reset.
REQ-055 Run st and pull reset_n low during MEM: expect next state FETCH, flags 0, and no mem_we, reg_write or pc_write after the edge.
